// File: rtl/cpu_axi_bridge_mo_if.sv
// AXI3 master-side channel bundle between the CPU bridge and the crossbar.
// The bridge drives AR/AW/W plus rready/bready; the slave drives the rest.
interface cpu_axi_bridge_mo_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/cpu_axi_bridge_mo.sv
// Bridge from two SRAM-like CPU ports (inst, data) to one AXI3 master with
// multiple outstanding reads per port, one write in flight and data-side RAW/WAR ordering.
module cpu_axi_bridge_mo #(
    parameter int         MAX_RD_OUTSTANDING = 4,
    parameter logic [3:0] INST_ID            = 4'd0,
    parameter logic [3:0] DATA_ID            = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    cpu_axi_bridge_mo_if.master axi
);

    localparam int              CNT_W    = $clog2(MAX_RD_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_RD_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    function automatic logic [3:0] strb_of(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] strb;
        case (size)
            2'd0:    strb = 4'b0001 << off;
            2'd1:    strb = 4'b0011 << off;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    logic             ar_full_r;
    logic [31:0]      ar_addr_r;
    logic [2:0]       ar_size_r;
    logic [3:0]       ar_id_r;
    logic [CNT_W-1:0] rd_cnt_inst_r;
    logic [CNT_W-1:0] rd_cnt_data_r;
    logic             wr_busy_r;
    logic             aw_pend_r;
    logic             w_pend_r;
    logic             wr_owner_r;
    logic [31:0]      wr_addr_r;
    logic [1:0]       wr_size_r;
    logic [31:0]      wr_data_r;

    logic data_raw_s, data_rd_acc_s, data_wr_acc_s, data_acc_s;
    logic inst_rd_ok_s, inst_wr_ok_s, inst_rd_acc_s, inst_wr_acc_s;
    logic rd_acc_s, wr_acc_s;
    logic r_inst_hit_s, r_data_hit_s, dec_inst_s, dec_data_s, b_done_s;
    logic unused_s;

    // Data side has priority; a late R beat for a port with nothing outstanding is dropped.
    assign data_raw_s    = wr_busy_r & (data_addr[31:2] == wr_addr_r[31:2]);
    assign data_rd_acc_s = resetn & data_req & ~data_wr & ~ar_full_r
                         & (rd_cnt_data_r < CNT_MAX) & ~data_raw_s;
    assign data_wr_acc_s = resetn & data_req & data_wr & ~wr_busy_r & ~ar_full_r
                         & (rd_cnt_data_r == CNT_ZERO);
    assign data_acc_s    = data_rd_acc_s | data_wr_acc_s;
    assign inst_rd_ok_s  = resetn & inst_req & ~inst_wr & ~ar_full_r & (rd_cnt_inst_r < CNT_MAX);
    assign inst_wr_ok_s  = resetn & inst_req & inst_wr & ~wr_busy_r & ~ar_full_r;
    assign inst_rd_acc_s = inst_rd_ok_s & ~data_acc_s;
    assign inst_wr_acc_s = inst_wr_ok_s & ~data_acc_s;
    assign rd_acc_s      = data_rd_acc_s | inst_rd_acc_s;
    assign wr_acc_s      = data_wr_acc_s | inst_wr_acc_s;

    assign r_inst_hit_s  = resetn & axi.rvalid & (axi.rid == INST_ID) & (rd_cnt_inst_r != CNT_ZERO);
    assign r_data_hit_s  = resetn & axi.rvalid & (axi.rid == DATA_ID) & (rd_cnt_data_r != CNT_ZERO);
    assign dec_inst_s    = r_inst_hit_s & axi.rlast;
    assign dec_data_s    = r_data_hit_s & axi.rlast;
    assign b_done_s      = resetn & axi.bvalid & wr_busy_r & ~aw_pend_r & ~w_pend_r;

    assign inst_addr_ok  = inst_rd_acc_s | inst_wr_acc_s;
    assign data_addr_ok  = data_acc_s;
    assign inst_data_ok  = r_inst_hit_s | (b_done_s & ~wr_owner_r);
    assign data_data_ok  = r_data_hit_s | (b_done_s & wr_owner_r);
    assign inst_rdata    = axi.rdata;
    assign data_rdata    = axi.rdata;

    assign axi.arid    = ar_id_r;
    assign axi.araddr  = ar_addr_r;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = ar_size_r;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = ar_full_r;
    assign axi.rready  = 1'b1;
    assign axi.awid    = 4'd0;
    assign axi.awaddr  = wr_addr_r;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = {1'b0, wr_size_r};
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'b0000;
    assign axi.awprot  = 3'b000;
    assign axi.awvalid = aw_pend_r;
    assign axi.wid     = 4'd0;
    assign axi.wdata   = wr_data_r;
    assign axi.wstrb   = strb_of(wr_size_r, wr_addr_r[1:0]);
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = w_pend_r;
    assign axi.bready  = 1'b1;

    assign unused_s = ^{axi.rresp, axi.bid, axi.bresp};

    // AR holding register: loaded by the accepted read, emptied by the AR handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_full_r <= 1'b0;
            ar_addr_r <= 32'd0;
            ar_size_r <= 3'd0;
            ar_id_r   <= 4'd0;
        end else if (rd_acc_s) begin
            ar_full_r <= 1'b1;
            ar_addr_r <= data_rd_acc_s ? data_addr : inst_addr;
            ar_size_r <= {1'b0, (data_rd_acc_s ? data_size : inst_size)};
            ar_id_r   <= data_rd_acc_s ? DATA_ID : INST_ID;
        end else if (axi.arvalid && axi.arready) begin
            ar_full_r <= 1'b0;
        end
    end

    // Per-port outstanding read counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_cnt_inst_r <= CNT_ZERO;
            rd_cnt_data_r <= CNT_ZERO;
        end else begin
            case ({inst_rd_acc_s, dec_inst_s})
                2'b10:   rd_cnt_inst_r <= rd_cnt_inst_r + CNT_ONE;
                2'b01:   rd_cnt_inst_r <= rd_cnt_inst_r - CNT_ONE;
                default: rd_cnt_inst_r <= rd_cnt_inst_r;
            endcase
            case ({data_rd_acc_s, dec_data_s})
                2'b10:   rd_cnt_data_r <= rd_cnt_data_r + CNT_ONE;
                2'b01:   rd_cnt_data_r <= rd_cnt_data_r - CNT_ONE;
                default: rd_cnt_data_r <= rd_cnt_data_r;
            endcase
        end
    end

    // Single write slot; AW and W retire independently, B only after both.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_busy_r  <= 1'b0;
            aw_pend_r  <= 1'b0;
            w_pend_r   <= 1'b0;
            wr_owner_r <= 1'b0;
            wr_addr_r  <= 32'd0;
            wr_size_r  <= 2'd0;
            wr_data_r  <= 32'd0;
        end else if (wr_acc_s) begin
            wr_busy_r  <= 1'b1;
            aw_pend_r  <= 1'b1;
            w_pend_r   <= 1'b1;
            wr_owner_r <= data_wr_acc_s;
            wr_addr_r  <= data_wr_acc_s ? data_addr : inst_addr;
            wr_size_r  <= data_wr_acc_s ? data_size : inst_size;
            wr_data_r  <= data_wr_acc_s ? data_wdata : inst_wdata;
        end else begin
            if (axi.awvalid && axi.awready) aw_pend_r <= 1'b0;
            if (axi.wvalid && axi.wready)   w_pend_r  <= 1'b0;
            if (b_done_s)                   wr_busy_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_axi_bridge_mo.sv
// Directed bench for cpu_axi_bridge_mo: the bench plays both CPU ports and the AXI slave.
module tb_cpu_axi_bridge_mo;
    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;

    int chk_cnt;
    int fail_cnt;

    cpu_axi_bridge_mo_if axi ();

    cpu_axi_bridge_mo #(.MAX_RD_OUTSTANDING(4), .INST_ID(4'd0), .DATA_ID(4'd1)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .axi(axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic req, input logic wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
        data_req = req; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wdata;
    endtask

    task automatic set_inst(input logic req, input logic wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
        inst_req = req; inst_wr = wr; inst_size = size; inst_addr = addr; inst_wdata = wdata;
    endtask

    task automatic set_r(input logic v, input logic [3:0] id, input logic [31:0] d);
        axi.rvalid = v; axi.rid = id; axi.rdata = d; axi.rlast = 1'b1; axi.rresp = 2'b00;
    endtask

    initial begin
        chk_cnt = 0; fail_cnt = 0;
        resetn = 1'b0;
        set_inst(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        set_data(1'b1, 1'b0, 2'd2, 32'h0000_0040, 32'd0);
        set_r(1'b0, 4'd0, 32'd0);
        axi.arready = 1'b1; axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bvalid = 1'b0; axi.bid = 4'd0; axi.bresp = 2'b00;

        // ---- reset state ----
        step(); step();
        check_val("rst_arvalid", 32'(axi.arvalid), 32'd0);
        check_val("rst_awvalid", 32'(axi.awvalid), 32'd0);
        check_val("rst_wvalid", 32'(axi.wvalid), 32'd0);
        check_val("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
        check_val("rst_rready", 32'(axi.rready), 32'd1);
        resetn = 1'b1;
        data_req = 1'b0;

        // ---- single inst word read ----
        step();
        set_inst(1'b1, 1'b0, 2'd2, 32'hBFC0_0000, 32'd0);
        #1;
        check_val("t1_addr_ok", 32'(inst_addr_ok), 32'd1);
        check_val("t1_arvalid_early", 32'(axi.arvalid), 32'd0);
        step();
        inst_req = 1'b0;
        #1;
        check_val("t1_arvalid", 32'(axi.arvalid), 32'd1);
        check_val("t1_arid", 32'(axi.arid), 32'd0);
        check_val("t1_arsize", 32'(axi.arsize), 32'd2);
        check_val("t1_araddr", axi.araddr, 32'hBFC0_0000);
        check_val("t1_arlen", 32'(axi.arlen), 32'd0);
        check_val("t1_arburst", 32'(axi.arburst), 32'd1);
        step();
        check_val("t1_arvalid_clr", 32'(axi.arvalid), 32'd0);
        step();
        set_r(1'b1, 4'd0, 32'h1234_5678);
        #1;
        check_val("t1_data_ok", 32'(inst_data_ok), 32'd1);
        check_val("t1_rdata", inst_rdata, 32'h1234_5678);
        check_val("t1_data_side_quiet", 32'(data_data_ok), 32'd0);
        step();
        set_r(1'b0, 4'd0, 32'd0);
        #1;
        check_val("t1_data_ok_pulse", 32'(inst_data_ok), 32'd0);

        // ---- four data reads fill the data counter; the fifth waits for an R ----
        for (int i = 0; i < 4; i++) begin
            set_data(1'b1, 1'b0, 2'd2, 32'h0000_0100 + 32'(4 * i), 32'd0);
            #1;
            check_val($sformatf("t2_addr_ok%0d", i), 32'(data_addr_ok), 32'd1);
            step();
            check_val($sformatf("t2_busy_ok%0d", i), 32'(data_addr_ok), 32'd0);
            check_val($sformatf("t2_arid%0d", i), 32'(axi.arid), 32'd1);
            step();
        end
        set_data(1'b1, 1'b0, 2'd2, 32'h0000_0200, 32'd0);
        #1;
        check_val("t2_fifth_blocked", 32'(data_addr_ok), 32'd0);
        step();
        check_val("t2_fifth_still_blocked", 32'(data_addr_ok), 32'd0);
        set_r(1'b1, 4'd1, 32'h0000_00A0);
        #1;
        check_val("t2_first_r_ok", 32'(data_data_ok), 32'd1);
        check_val("t2_fifth_r_cycle", 32'(data_addr_ok), 32'd0);
        step();
        set_r(1'b0, 4'd0, 32'd0);
        #1;
        check_val("t2_fifth_accepted", 32'(data_addr_ok), 32'd1);
        step();
        data_req = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            set_r(1'b1, 4'd1, 32'h0000_00B0 + 32'(i));
            #1;
            check_val($sformatf("t2_drain_ok%0d", i), 32'(data_data_ok), 32'd1);
            step();
        end
        set_r(1'b0, 4'd0, 32'd0);

        // ---- interleaved inst/data reads, out-of-order responses ----
        set_data(1'b1, 1'b0, 2'd2, 32'h2000_0000, 32'd0);
        set_inst(1'b1, 1'b0, 2'd2, 32'h1000_0000, 32'd0);
        #1;
        check_val("t3_data_wins", 32'(data_addr_ok), 32'd1);
        check_val("t3_inst_loses", 32'(inst_addr_ok), 32'd0);
        step();
        data_req = 1'b0;
        #1;
        check_val("t3_inst_wait_ar", 32'(inst_addr_ok), 32'd0);
        check_val("t3_arid_data", 32'(axi.arid), 32'd1);
        step();
        check_val("t3_inst_accept", 32'(inst_addr_ok), 32'd1);
        step();
        inst_req = 1'b0;
        #1;
        check_val("t3_arid_inst", 32'(axi.arid), 32'd0);
        check_val("t3_araddr_inst", axi.araddr, 32'h1000_0000);
        step();
        set_r(1'b1, 4'd5, 32'hDEAD_BEEF);
        #1;
        check_val("t3_unknown_rid_inst", 32'(inst_data_ok), 32'd0);
        check_val("t3_unknown_rid_data", 32'(data_data_ok), 32'd0);
        step();
        set_r(1'b1, 4'd1, 32'hDDDD_0001);
        #1;
        check_val("t3_data_ok_first", 32'(data_data_ok), 32'd1);
        check_val("t3_inst_quiet", 32'(inst_data_ok), 32'd0);
        check_val("t3_data_rdata", data_rdata, 32'hDDDD_0001);
        step();
        set_r(1'b1, 4'd0, 32'h1111_0000);
        #1;
        check_val("t3_inst_ok_second", 32'(inst_data_ok), 32'd1);
        check_val("t3_data_quiet", 32'(data_data_ok), 32'd0);
        check_val("t3_inst_rdata", inst_rdata, 32'h1111_0000);
        step();
        set_r(1'b0, 4'd0, 32'd0);

        // ---- data byte write, AW before W, early B ignored ----
        set_data(1'b1, 1'b1, 2'd0, 32'h0000_1003, 32'hABAB_ABAB);
        #1;
        check_val("t4_addr_ok", 32'(data_addr_ok), 32'd1);
        step();
        data_req = 1'b0;
        #1;
        check_val("t4_awvalid", 32'(axi.awvalid), 32'd1);
        check_val("t4_wvalid", 32'(axi.wvalid), 32'd1);
        check_val("t4_wstrb", 32'(axi.wstrb), 32'h8);
        check_val("t4_awaddr", axi.awaddr, 32'h0000_1003);
        check_val("t4_awsize", 32'(axi.awsize), 32'd0);
        check_val("t4_wdata", axi.wdata, 32'hABAB_ABAB);
        check_val("t4_wlast", 32'(axi.wlast), 32'd1);
        axi.bvalid = 1'b1; axi.awready = 1'b1;
        #1;
        check_val("t4_early_b", 32'(data_data_ok), 32'd0);
        step();
        axi.bvalid = 1'b0; axi.awready = 1'b0; axi.wready = 1'b1;
        #1;
        check_val("t4_aw_done", 32'(axi.awvalid), 32'd0);
        check_val("t4_w_held", 32'(axi.wvalid), 32'd1);
        step();
        axi.wready = 1'b0;
        #1;
        check_val("t4_w_done", 32'(axi.wvalid), 32'd0);
        check_val("t4_no_ok_before_b", 32'(data_data_ok), 32'd0);
        axi.bvalid = 1'b1;
        #1;
        check_val("t4_b_ok", 32'(data_data_ok), 32'd1);
        step();
        axi.bvalid = 1'b0;
        #1;
        check_val("t4_b_pulse", 32'(data_data_ok), 32'd0);

        // ---- inst half write at 0x2002, W before AW ----
        set_inst(1'b1, 1'b1, 2'd1, 32'h0000_2002, 32'h1234_0000);
        #1;
        check_val("t4b_addr_ok", 32'(inst_addr_ok), 32'd1);
        step();
        inst_req = 1'b0; axi.wready = 1'b1;
        #1;
        check_val("t4b_wstrb", 32'(axi.wstrb), 32'hC);
        check_val("t4b_awvalid", 32'(axi.awvalid), 32'd1);
        step();
        axi.wready = 1'b0; axi.awready = 1'b1;
        #1;
        check_val("t4b_w_first", 32'(axi.wvalid), 32'd0);
        check_val("t4b_aw_held", 32'(axi.awvalid), 32'd1);
        step();
        axi.awready = 1'b0; axi.bvalid = 1'b1;
        #1;
        check_val("t4b_inst_ok", 32'(inst_data_ok), 32'd1);
        check_val("t4b_data_quiet", 32'(data_data_ok), 32'd0);
        step();
        axi.bvalid = 1'b0;

        // ---- RAW hazard against a pending write ----
        set_data(1'b1, 1'b1, 2'd2, 32'h0000_0100, 32'h0000_0055);
        #1;
        check_val("t5_wr_ok", 32'(data_addr_ok), 32'd1);
        step();
        set_data(1'b1, 1'b0, 2'd2, 32'h0000_0102, 32'd0);
        axi.awready = 1'b1; axi.wready = 1'b1;
        #1;
        check_val("t5_raw_block", 32'(data_addr_ok), 32'd0);
        step();
        axi.awready = 1'b0; axi.wready = 1'b0;
        #1;
        check_val("t5_raw_block2", 32'(data_addr_ok), 32'd0);
        data_addr = 32'h0000_0200;
        #1;
        check_val("t5_other_addr_ok", 32'(data_addr_ok), 32'd1);
        step();
        data_req = 1'b0;
        #1;
        check_val("t5_araddr", axi.araddr, 32'h0000_0200);
        step();
        axi.bvalid = 1'b1;
        #1;
        check_val("t5_b_ok", 32'(data_data_ok), 32'd1);
        step();
        axi.bvalid = 1'b0;
        set_data(1'b1, 1'b0, 2'd2, 32'h0000_0102, 32'd0);
        #1;
        check_val("t5_raw_released", 32'(data_addr_ok), 32'd1);
        step();
        data_req = 1'b0;
        step();

        // ---- reset with two data reads outstanding and an AR pending ----
        axi.arready = 1'b0;
        set_inst(1'b1, 1'b0, 2'd2, 32'h0000_0300, 32'd0);
        #1;
        check_val("t6_inst_ok", 32'(inst_addr_ok), 32'd1);
        step();
        inst_req = 1'b0;
        set_data(1'b1, 1'b1, 2'd2, 32'h0000_0400, 32'h0000_0077);
        #1;
        check_val("t6_ar_pending", 32'(axi.arvalid), 32'd1);
        check_val("t6_war_block", 32'(data_addr_ok), 32'd0);
        resetn = 1'b0;
        #1;
        check_val("t6_rst_arvalid", 32'(axi.arvalid), 32'd0);
        check_val("t6_rst_addr_ok", 32'(data_addr_ok), 32'd0);
        step();
        step();
        resetn = 1'b1;
        data_req = 1'b0;
        set_r(1'b1, 4'd1, 32'h5555_AAAA);
        #1;
        check_val("t6_stale_r_data", 32'(data_data_ok), 32'd0);
        axi.rid = 4'd0;
        #1;
        check_val("t6_stale_r_inst", 32'(inst_data_ok), 32'd0);
        step();
        set_r(1'b0, 4'd0, 32'd0);
        axi.bvalid = 1'b1;
        #1;
        check_val("t6_stale_b", 32'(data_data_ok | inst_data_ok), 32'd0);
        step();
        axi.bvalid = 1'b0;
        set_data(1'b1, 1'b1, 2'd2, 32'h0000_0400, 32'h0000_0077);
        #1;
        check_val("t6_cnt_cleared", 32'(data_addr_ok), 32'd1);
        step();
        data_req = 1'b0;
        #1;
        check_val("t6_awvalid", 32'(axi.awvalid), 32'd1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
        $finish;
    end
endmodule
